// File: rtl/limn2600_bus_pkg.sv
// Shared definitions for the limn2600 SRAM bus arbiter: FSM encoding,
// default widths and the watchdog counter sizing helper.
package limn2600_bus_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_state_e;

    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT     = 255;

    // A disabled watchdog still gets a 1-bit counter so the port widths stay legal.
    function automatic int wdog_width(input int timeout);
        if (timeout < 1) begin
            return 1;
        end else begin
            return $clog2(timeout + 1);
        end
    endfunction

endpackage

// File: rtl/limn2600_rr_picker.sv
// Combinational round-robin selector: returns the first requester strictly
// after `last` in circular order, wrapping back to `last` itself.
module limn2600_rr_picker
    import limn2600_bus_pkg::*;
#(
    parameter int N     = DEF_NUM_MASTERS,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] next
);

    // Scan from farthest to nearest so the nearest requester after `last` wins.
    always_comb begin
        int               tmp;
        logic [IDX_W-1:0] cand;
        tmp   = 0;
        cand  = '0;
        valid = 1'b0;
        next  = last;
        for (int i = N; i >= 1; i--) begin
            tmp  = (int'(last) + i) % N;
            cand = IDX_W'(tmp);
            if (req[cand]) begin
                valid = 1'b1;
                next  = cand;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/limn2600_bus_arbiter.sv
// Round-robin arbiter sharing one SRAM slave port between several masters,
// with a bus watchdog that aborts transactions the slave never completes.
module limn2600_bus_arbiter
    import limn2600_bus_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_cs,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]        m_rdy,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic                          s_cs,
    output logic                          s_we,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_rdy,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int WD_W  = wdog_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LIMIT = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX   = '1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

    bus_state_e             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       last_q,  last_d;
    logic [WD_W-1:0]        wdog_q,  wdog_d;
    logic [NUM_MASTERS-1:0] m_err_q, m_err_d;

    logic                   pick_valid_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic                   own_cs_s;
    logic                   wd_expire_s;

    limn2600_rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (m_cs),
        .last  (last_q),
        .valid (pick_valid_s),
        .next  (pick_idx_s)
    );

    assign own_cs_s    = m_cs[owner_q];
    assign wd_expire_s = (TIMEOUT != 0) && (wdog_q == WD_LIMIT);

    // Slave-side muxing and master-side steering, all decoded from the current owner.
    always_comb begin
        busy    = (state_q == ST_BUSY);
        grant   = '0;
        s_cs    = 1'b0;
        s_we    = 1'b0;
        s_addr  = m_addr[int'(owner_q) * ADDR_W +: ADDR_W];
        s_wdata = m_wdata[int'(owner_q) * DATA_W +: DATA_W];
        m_rdata = s_rdata;
        if (state_q == ST_BUSY) begin
            grant[owner_q] = 1'b1;
            s_cs           = own_cs_s;
            s_we           = m_we[owner_q];
        end else begin
            grant = '0;
        end
        m_rdy = grant & {NUM_MASTERS{s_rdy & own_cs_s}};
        m_err = m_err_q;
    end

    // Next-state logic; completion outranks abandon, which outranks the watchdog.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        m_err_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ST_BUSY;
                    owner_d = pick_idx_s;
                    wdog_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (s_rdy || !own_cs_s) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end else if (wd_expire_s) begin
                    state_d          = ST_IDLE;
                    last_d           = owner_q;
                    m_err_d[owner_q] = 1'b1;
                end else if (wdog_q != WD_MAX) begin
                    wdog_d = wdog_q + 1'b1;
                end else begin
                    wdog_d = wdog_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset leaves master 0 first in line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            wdog_q  <= '0;
            m_err_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            m_err_q <= m_err_d;
        end
    end

endmodule

// File: tb/tb_limn2600_bus_arbiter.sv
// Directed bench for limn2600_bus_arbiter: two masters, watchdog of 4 cycles,
// completions checked against a scoreboard of expected rdy/err/rdata records.
module tb_limn2600_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        string       tag;
        logic [1:0]  rdy;
        logic [1:0]  err;
        logic        chk_data;
        logic [31:0] rdata;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    m_cs;
    logic [N-1:0]    m_we;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_rdy;
    logic [N-1:0]    m_err;
    logic            s_cs;
    logic            s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [DW-1:0]   s_rdata;
    logic            s_rdy;
    logic [N-1:0]    grant;
    logic            busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [31:0] addr_tab  [N] = '{32'h0000_0100, 32'h0000_0200};
    logic [31:0] wdata_tab [N] = '{32'hAAAA_0000, 32'h0000_0055};
    logic        we_tab    [N] = '{1'b0, 1'b1};

    limn2600_bus_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT     (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_cs    (m_cs),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_rdy   (m_rdy),
        .m_err   (m_err),
        .s_cs    (s_cs),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_rdy   (s_rdy),
        .grant   (grant),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every rdy/err strobe must match the oldest expected record.
    always @(negedge clk) begin
        if (rst === 1'b1 && (m_rdy !== 2'b00 || m_err !== 2'b00)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_strobe", {60'd0, m_rdy, m_err}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.tag, "_rdy"}, 64'(m_rdy), 64'(mon_e.rdy));
                chk({mon_e.tag, "_err"}, 64'(m_err), 64'(mon_e.err));
                if (mon_e.chk_data) begin
                    chk({mon_e.tag, "_rdata"}, 64'(m_rdata), 64'(mon_e.rdata));
                end
            end
        end
    end

    // Called in the first BUSY cycle of master `own`; leaves the bench just after the
    // arbitration edge that follows the one idle cycle.
    task automatic txn(input int own, input int waits, input logic [31:0] rd,
                       input logic [1:0] next_cs);
        exp_t       x;
        logic [1:0] g;
        g          = 2'b01 << own;
        x.tag      = $sformatf("txn_m%0d", own);
        x.rdy      = g;
        x.err      = 2'b00;
        x.chk_data = !we_tab[own];
        x.rdata    = rd;
        sb_q.push_back(x);
        chk("grant", 64'(grant), 64'(g));
        chk("busy", 64'(busy), 64'd1);
        chk("s_cs", 64'(s_cs), 64'd1);
        chk("s_we", 64'(s_we), 64'(we_tab[own]));
        chk("s_addr", 64'(s_addr), 64'(addr_tab[own]));
        chk("s_wdata", 64'(s_wdata), 64'(wdata_tab[own]));
        for (int k = 0; k < waits; k++) begin
            cyc();
            chk("s_addr_hold", 64'(s_addr), 64'(addr_tab[own]));
            chk("m_rdy_wait", 64'(m_rdy), 64'd0);
        end
        s_rdy   = 1'b1;
        s_rdata = rd;
        #1;
        chk("m_rdy_pulse", 64'(m_rdy), 64'(g));
        cyc();
        s_rdy   = 1'b0;
        s_rdata = 32'h0;
        m_cs    = next_cs;
        #1;
        chk("idle_grant", 64'(grant), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_m_rdy", 64'(m_rdy), 64'd0);
        cyc();
    endtask

    initial begin
        exp_t x;
        rst     = 1'b0;
        m_cs    = 2'b11;
        m_we    = {we_tab[1], we_tab[0]};
        m_addr  = {addr_tab[1], addr_tab[0]};
        m_wdata = {wdata_tab[1], wdata_tab[0]};
        s_rdata = 32'h0;
        s_rdy   = 1'b1;

        repeat (3) cyc();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_s_cs", 64'(s_cs), 64'd0);
        chk("rst_m_rdy", 64'(m_rdy), 64'd0);
        chk("rst_m_err", 64'(m_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        s_rdy = 1'b0;
        rst   = 1'b1;
        cyc();

        // Single read with a 3-cycle slave, then strict alternation under contention.
        txn(0, 3, 32'hDEAD_BEEF, 2'b11);
        txn(1, 1, 32'h0000_0000, 2'b11);
        txn(0, 1, 32'hCAFE_0001, 2'b11);
        txn(1, 1, 32'h0000_0000, 2'b00);

        // Watchdog abort of master 1.
        m_cs = 2'b10;
        cyc();
        x.tag = "timeout_m1"; x.rdy = 2'b00; x.err = 2'b10; x.chk_data = 1'b0; x.rdata = 32'h0;
        sb_q.push_back(x);
        chk("to_grant", 64'(grant), 64'd2);
        for (int k = 0; k < 4; k++) begin
            chk("to_s_cs_high", 64'(s_cs), 64'd1);
            chk("to_m_rdy", 64'(m_rdy), 64'd0);
            cyc();
        end
        chk("to_s_cs_drop", 64'(s_cs), 64'd0);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_m_err", 64'(m_err), 64'd2);
        m_cs = 2'b01;
        cyc();
        chk("to_m_err_clear", 64'(m_err), 64'd0);
        txn(0, 1, 32'h0BAD_F00D, 2'b00);

        // Slave completes in the very cycle the watchdog would expire.
        m_cs = 2'b01;
        cyc();
        x.tag = "edge_m0"; x.rdy = 2'b01; x.err = 2'b00; x.chk_data = 1'b1; x.rdata = 32'h1234_5678;
        sb_q.push_back(x);
        repeat (3) begin
            chk("edge_s_cs", 64'(s_cs), 64'd1);
            cyc();
        end
        s_rdy   = 1'b1;
        s_rdata = 32'h1234_5678;
        #1;
        chk("edge_m_rdy", 64'(m_rdy), 64'd1);
        cyc();
        s_rdy = 1'b0;
        m_cs  = 2'b00;
        #1;
        chk("edge_busy", 64'(busy), 64'd0);
        chk("edge_m_err", 64'(m_err), 64'd0);

        // Abandon: owner drops cs mid-transaction.
        m_cs = 2'b01;
        cyc();
        chk("ab_grant", 64'(grant), 64'd1);
        m_cs = 2'b00;
        #1;
        chk("ab_s_cs", 64'(s_cs), 64'd0);
        chk("ab_m_rdy", 64'(m_rdy), 64'd0);
        cyc();
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_grant_idle", 64'(grant), 64'd0);
        cyc();
        chk("ab_m_err", 64'(m_err), 64'd0);

        // Asynchronous reset while master 1 owns the bus.
        m_cs = 2'b10;
        cyc();
        chk("mr_grant", 64'(grant), 64'd2);
        m_cs = 2'b11;
        #1;
        chk("mr_s_cs_before", 64'(s_cs), 64'd1);
        rst = 1'b0;
        #1;
        chk("mr_s_cs_now", 64'(s_cs), 64'd0);
        chk("mr_grant_now", 64'(grant), 64'd0);
        chk("mr_busy_now", 64'(busy), 64'd0);
        cyc();
        rst = 1'b1;
        cyc();
        txn(0, 1, 32'h5A5A_5A5A, 2'b00);

        repeat (2) cyc();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
